// File: rtl/sram_req_initiator_if.sv
// Client-side request/response bus of sram_req_initiator (valid/ready both ways).
interface sram_req_initiator_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  Req_Valid_SI;
  logic                  Req_Ready_SO;
  logic                  Req_We_SI;
  logic [7:0]            Req_BEn_SI;
  logic [ADDR_WIDTH-1:0] Req_Addr_DI;
  logic [63:0]           Req_WrData_DI;
  logic                  Rsp_Valid_SO;
  logic                  Rsp_Ready_SI;
  logic                  Rsp_We_SO;
  logic [63:0]           Rsp_RdData_DO;

  modport master (
    output Req_Valid_SI, Req_We_SI, Req_BEn_SI, Req_Addr_DI, Req_WrData_DI, Rsp_Ready_SI,
    input  Req_Ready_SO, Rsp_Valid_SO, Rsp_We_SO, Rsp_RdData_DO
  );

  modport slave (
    input  Req_Valid_SI, Req_We_SI, Req_BEn_SI, Req_Addr_DI, Req_WrData_DI, Rsp_Ready_SI,
    output Req_Ready_SO, Rsp_Valid_SO, Rsp_We_SO, Rsp_RdData_DO
  );
endinterface

// File: rtl/sram_req_initiator.sv
// Credit-protected initiator for a 1/2-cycle-latency byte-enable SRAM.
// Optional SRAM_REQ_BYPASS_EN: respond straight from the RAM when the FIFO is empty.
module sram_req_initiator #(
  parameter int ADDR_WIDTH = 10,
  parameter int OUT_REGS   = 0,
  parameter int RESP_DEPTH = 4,
  localparam int CW        = $clog2(RESP_DEPTH + 1)
) (
  input  logic                  Clk_CI,
  input  logic                  Rst_RI,
  sram_req_initiator_if.slave   bus,
  output logic                  CSel_SO,
  output logic                  WrEn_SO,
  output logic [7:0]            BEn_SO,
  output logic [ADDR_WIDTH-1:0] Addr_DO,
  output logic [63:0]           WrData_DO,
  input  logic [63:0]           RdData_DI,
  output logic [CW-1:0]         Outstanding_SO
);
  localparam int LAT = 1 + OUT_REGS;
  localparam int PW  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

  typedef struct packed {
    logic        we;
    logic [63:0] data;
  } rsp_t;

  logic [CW-1:0]  used_q, used_d, cnt_q, cnt_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LAT-1:0] vld_pipe_q, vld_pipe_d, we_pipe_q, we_pipe_d;
  rsp_t           fifo_q [RESP_DEPTH];
  rsp_t           rsp;
  logic           req_rdy, req_hs, rsp_vld, rsp_hs, push, pop, trk_last, fifo_empty, fifo_full;

  assign req_rdy    = ~Rst_RI & (used_q < CW'(RESP_DEPTH));
  assign req_hs     = bus.Req_Valid_SI & req_rdy;
  assign trk_last   = vld_pipe_q[LAT-1];
  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CW'(RESP_DEPTH));

`ifdef SRAM_REQ_BYPASS_EN
  // Empty FIFO: the RAM word goes straight out and skips the queue if taken now.
  assign rsp_vld = ~Rst_RI & (~fifo_empty | trk_last);
  assign rsp     = fifo_empty ? rsp_t'{we: we_pipe_q[LAT-1], data: RdData_DI} : fifo_q[rd_ptr_q];
  assign push    = trk_last & ~(fifo_empty & bus.Rsp_Ready_SI);
  assign pop     = ~fifo_empty & bus.Rsp_Ready_SI;
`else
  assign rsp_vld = ~Rst_RI & ~fifo_empty;
  assign rsp     = fifo_q[rd_ptr_q];
  assign push    = trk_last;
  assign pop     = rsp_vld & bus.Rsp_Ready_SI;
`endif
  assign rsp_hs  = rsp_vld & bus.Rsp_Ready_SI;

  assign bus.Req_Ready_SO  = req_rdy;
  assign bus.Rsp_Valid_SO  = rsp_vld;
  assign bus.Rsp_We_SO     = rsp_vld & rsp.we;
  assign bus.Rsp_RdData_DO = rsp_vld ? rsp.data : 64'd0;

  assign CSel_SO        = req_hs;
  assign WrEn_SO        = req_hs & bus.Req_We_SI;
  assign BEn_SO         = req_hs ? bus.Req_BEn_SI : 8'd0;
  assign Addr_DO        = Rst_RI ? '0 : bus.Req_Addr_DI;
  assign WrData_DO      = Rst_RI ? 64'd0 : bus.Req_WrData_DI;
  assign Outstanding_SO = used_q;

  always_comb begin
    used_d = used_q;
    if (req_hs & ~rsp_hs)      used_d = used_q + CW'(1);
    else if (~req_hs & rsp_hs) used_d = used_q - CW'(1);

    cnt_d = cnt_q;
    if (push & ~pop)      cnt_d = cnt_q + CW'(1);
    else if (~push & pop) cnt_d = cnt_q - CW'(1);

    wr_ptr_d = wr_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == PW'(RESP_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    rd_ptr_d = rd_ptr_q;
    if (pop)  rd_ptr_d = (rd_ptr_q == PW'(RESP_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);

    vld_pipe_d    = vld_pipe_q;
    we_pipe_d     = we_pipe_q;
    vld_pipe_d[0] = req_hs;
    we_pipe_d[0]  = req_hs & bus.Req_We_SI;
    for (int i = 1; i < LAT; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      we_pipe_d[i]  = we_pipe_q[i-1];
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      used_q     <= '0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      vld_pipe_q <= '0;
      we_pipe_q  <= '0;
    end else begin
      used_q     <= used_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      vld_pipe_q <= vld_pipe_d;
      we_pipe_q  <= we_pipe_d;
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (push) fifo_q[wr_ptr_q] <= rsp_t'{we: we_pipe_q[LAT-1], data: RdData_DI};
  end

  a_no_overflow: assert property (@(posedge Clk_CI) disable iff (Rst_RI) !(push && fifo_full));
endmodule

// File: tb/tb_sram_req_initiator.sv
// Directed bench for sram_req_initiator with a behavioural byte-enable RAM.
module tb_sram_req_initiator;
  localparam int AW       = 10;
  localparam int OUT_REGS = 0;
  localparam int DEPTH    = 4;
  localparam int LAT      = 1 + OUT_REGS;
`ifdef SRAM_REQ_BYPASS_EN
  localparam int EXP_LAT  = LAT;
`else
  localparam int EXP_LAT  = LAT + 1;
`endif
  localparam logic [63:0] BASE = 64'hA5A5_0000_0000_0000;

  logic          Clk, Rst;
  logic          CSel, WrEn;
  logic [7:0]    BEn;
  logic [AW-1:0] Addr;
  logic [63:0]   WrData, RdData;
  logic [2:0]    Outst;

  sram_req_initiator_if #(.ADDR_WIDTH(AW)) bus ();

  sram_req_initiator #(.ADDR_WIDTH(AW), .OUT_REGS(OUT_REGS), .RESP_DEPTH(DEPTH)) dut (
    .Clk_CI(Clk), .Rst_RI(Rst), .bus(bus),
    .CSel_SO(CSel), .WrEn_SO(WrEn), .BEn_SO(BEn), .Addr_DO(Addr),
    .WrData_DO(WrData), .RdData_DI(RdData), .Outstanding_SO(Outst)
  );

  initial begin
    Clk = 0;
    forever #5 Clk = ~Clk;
  end

  // RAM model: read-before-write, optional output register
  logic [63:0] ram [1024];
  logic [63:0] rd_q, rd_q2;
  initial for (int i = 0; i < 1024; i++) ram[i] = BASE | 64'(i);
  always @(posedge Clk) begin
    if (CSel) begin
      rd_q <= ram[Addr];
      if (WrEn) for (int b = 0; b < 8; b++) if (BEn[b]) ram[Addr][8*b +: 8] <= WrData[8*b +: 8];
    end
    rd_q2 <= rd_q;
  end
  assign RdData = (OUT_REGS != 0) ? rd_q2 : rd_q;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  logic [63:0] rq_data[$];
  bit          rq_we[$];
  int          rq_cyc[$];
  always @(negedge Clk) begin
    if (!Rst && bus.Rsp_Valid_SO && bus.Rsp_Ready_SI) begin
      rq_data.push_back(bus.Rsp_RdData_DO);
      rq_we.push_back(bus.Rsp_We_SO);
      rq_cyc.push_back(cyc);
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic clear_q();
    rq_data.delete(); rq_we.delete(); rq_cyc.delete();
  endtask

  // Holds the request until accepted; returns at posedge+1 with valid still high.
  task automatic send(input bit we, input logic [7:0] ben, input logic [AW-1:0] a,
                      input logic [63:0] d, output int hs, output bit ok);
    bus.Req_We_SI = we; bus.Req_BEn_SI = ben; bus.Req_Addr_DI = a; bus.Req_WrData_DI = d;
    bus.Req_Valid_SI = 1; ok = 0; hs = -1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge Clk);
      if (bus.Req_Ready_SO) begin ok = 1; hs = cyc; end
      @(posedge Clk); #1;
    end
  endtask

  task automatic wait_rsp(input int n, output bit ok);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge Clk);
      if (rq_data.size() >= n) begin ok = 1; break; end
    end
    @(posedge Clk); #1;
  endtask

  task automatic test_reset();
    Rst = 1; bus.Req_Valid_SI = 1; bus.Req_We_SI = 1; bus.Req_BEn_SI = 8'hFF;
    bus.Req_Addr_DI = 10'h3FF; bus.Req_WrData_DI = 64'hDEAD; bus.Rsp_Ready_SI = 1;
    @(posedge Clk); #1;
    @(negedge Clk);
    n_chk++; if ({CSel, WrEn, BEn} !== 10'd0) begin n_fail++; $display("FAIL rst_pins: got %b want 0", {CSel, WrEn, BEn}); end
    n_chk++; if (Addr !== '0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", Addr); end
    n_chk++; if (bus.Req_Ready_SO !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", bus.Req_Ready_SO); end
    n_chk++; if (bus.Rsp_Valid_SO !== 1'b0 || Outst !== 3'd0) begin n_fail++; $display("FAIL rst_rsp: got v=%b o=%0d want 0/0", bus.Rsp_Valid_SO, Outst); end
    @(posedge Clk); #1;
    Rst = 0; bus.Req_Valid_SI = 0;
    @(negedge Clk);
    n_chk++; if (bus.Req_Ready_SO !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready: got %b want 1", bus.Req_Ready_SO); end
    n_chk++; if (bus.Rsp_Valid_SO !== 1'b0 || bus.Rsp_RdData_DO !== 64'd0 || Outst !== 3'd0) begin
      n_fail++; $display("FAIL post_rst_out: got v=%b d=%h o=%0d want 0", bus.Rsp_Valid_SO, bus.Rsp_RdData_DO, Outst); end
    @(posedge Clk); #1;
  endtask

  task automatic test_issue();
    bit ok;
    clear_q();
    bus.Req_We_SI = 1; bus.Req_BEn_SI = 8'h3C; bus.Req_Addr_DI = 10'h003;
    bus.Req_WrData_DI = 64'h0102030405060708; bus.Req_Valid_SI = 1;
    @(negedge Clk);
    n_chk++; if ({CSel, WrEn, BEn} !== {1'b1, 1'b1, 8'h3C}) begin n_fail++; $display("FAIL issue_wr_pins: got %b want 11_00111100", {CSel, WrEn, BEn}); end
    n_chk++; if (Addr !== 10'h003 || WrData !== 64'h0102030405060708) begin n_fail++; $display("FAIL issue_fields: got %h/%h", Addr, WrData); end
    @(posedge Clk); #1;
    bus.Req_Valid_SI = 0;
    @(negedge Clk);
    n_chk++; if ({CSel, WrEn, BEn} !== 10'd0) begin n_fail++; $display("FAIL idle_pins: got %b want 0", {CSel, WrEn, BEn}); end
    @(posedge Clk); #1;
    wait_rsp(1, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL issue_rsp_timeout: got none want 1 response"); end
  endtask

  task automatic test_write_read();
    int hw, hr; bit ok1, ok2, ok3;
    clear_q(); bus.Rsp_Ready_SI = 1;
    send(1, 8'hFF, 10'h005, 64'h1122334455667788, hw, ok1);
    send(0, 8'hF0, 10'h005, 64'h0, hr, ok2);
    bus.Req_Valid_SI = 0;
    wait_rsp(2, ok3);
    n_chk++; if (!(ok1 && ok2 && ok3)) begin n_fail++; $display("FAIL wr_rd_timeout: got %b%b%b want 111", ok1, ok2, ok3); end
    n_chk++; if (rq_we[0] !== 1'b1 || rq_data[0] !== (BASE | 64'h5)) begin
      n_fail++; $display("FAIL wr_rsp: got we=%b d=%h want 1/%h", rq_we[0], rq_data[0], BASE | 64'h5); end
    n_chk++; if (rq_we[1] !== 1'b0 || rq_data[1] !== 64'h1122334455667788) begin
      n_fail++; $display("FAIL rd_rsp: got we=%b d=%h want 0/1122334455667788", rq_we[1], rq_data[1]); end
    n_chk++; if (rq_cyc[1] !== hr + EXP_LAT) begin n_fail++; $display("FAIL rd_latency: got %0d want %0d", rq_cyc[1] - hr, EXP_LAT); end
  endtask

  task automatic test_partial_write();
    int h; bit ok1, ok2, ok3;
    clear_q(); bus.Rsp_Ready_SI = 1;
    send(1, 8'h0F, 10'h005, 64'hAAAAAAAA_BBBBBBBB, h, ok1);
    send(0, 8'h00, 10'h005, 64'h0, h, ok2);
    bus.Req_Valid_SI = 0;
    wait_rsp(2, ok3);
    n_chk++; if (!(ok1 && ok2 && ok3)) begin n_fail++; $display("FAIL partial_timeout: got %b%b%b want 111", ok1, ok2, ok3); end
    n_chk++; if (rq_data[0] !== 64'h1122334455667788 || rq_we[0] !== 1'b1) begin
      n_fail++; $display("FAIL partial_wr_rsp: got %h want 1122334455667788", rq_data[0]); end
    n_chk++; if (rq_data[1] !== 64'h11223344_BBBBBBBB) begin
      n_fail++; $display("FAIL partial_rd: got %h want 11223344bbbbbbbb", rq_data[1]); end
  endtask

  task automatic test_backpressure();
    int acc; bit ok;
    clear_q(); bus.Rsp_Ready_SI = 0; acc = 0;
    bus.Req_We_SI = 0; bus.Req_BEn_SI = 8'h00; bus.Req_WrData_DI = 64'h0;
    for (int c = 0; c < 8; c++) begin
      bus.Req_Addr_DI = AW'(10 + acc); bus.Req_Valid_SI = 1;
      @(negedge Clk);
      if (bus.Req_Ready_SO) acc++;
      @(posedge Clk); #1;
    end
    @(negedge Clk);
    n_chk++; if (acc !== 4) begin n_fail++; $display("FAIL bp_accepts: got %0d want 4", acc); end
    n_chk++; if (Outst !== 3'd4 || bus.Req_Ready_SO !== 1'b0) begin
      n_fail++; $display("FAIL bp_credits: got o=%0d rdy=%b want 4/0", Outst, bus.Req_Ready_SO); end
    n_chk++; if (bus.Rsp_Valid_SO !== 1'b1 || bus.Rsp_RdData_DO !== (BASE | 64'd10)) begin
      n_fail++; $display("FAIL bp_head_hold: got v=%b d=%h want 1/%h", bus.Rsp_Valid_SO, bus.Rsp_RdData_DO, BASE | 64'd10); end
    @(posedge Clk); #1;
    bus.Rsp_Ready_SI = 1;
    for (int c = 0; c < 30 && acc < 6; c++) begin
      bus.Req_Addr_DI = AW'(10 + acc); bus.Req_Valid_SI = 1;
      @(negedge Clk);
      if (bus.Req_Ready_SO) acc++;
      @(posedge Clk); #1;
    end
    bus.Req_Valid_SI = 0;
    wait_rsp(6, ok);
    n_chk++; if (!ok || acc !== 6) begin n_fail++; $display("FAIL bp_release: got acc=%0d rsp=%0d want 6/6", acc, rq_data.size()); end
    for (int i = 0; i < 6; i++) begin
      n_chk++; if (rq_data[i] !== (BASE | 64'(10 + i))) begin
        n_fail++; $display("FAIL bp_order[%0d]: got %h want %h", i, rq_data[i], BASE | 64'(10 + i)); end
    end
  endtask

  task automatic test_back_to_back();
    int h0, h, nok; bit ok;
    clear_q(); bus.Rsp_Ready_SI = 1; nok = 0; h0 = 0;
    for (int i = 0; i < 100; i++) begin
      send(0, 8'h00, AW'(100 + i), 64'h0, h, ok);
      if (!ok) nok++;
      if (i == 0) h0 = h;
    end
    bus.Req_Valid_SI = 0;
    n_chk++; if (nok != 0 || h - h0 != 99) begin n_fail++; $display("FAIL b2b_bubbles: got span=%0d want 99", h - h0); end
    wait_rsp(100, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL b2b_timeout: got %0d want 100", rq_data.size()); end
    for (int i = 0; i < 100; i++) begin
      n_chk++; if (rq_data[i] !== (BASE | 64'(100 + i))) begin
        n_fail++; $display("FAIL b2b_data[%0d]: got %h want %h", i, rq_data[i], BASE | 64'(100 + i)); end
    end
  endtask

  task automatic test_reset_inflight();
    int h; bit ok;
    clear_q(); bus.Rsp_Ready_SI = 0;
    for (int i = 0; i < 3; i++) send(0, 8'h00, AW'(20 + i), 64'h0, h, ok);
    bus.Req_Valid_SI = 0;
    Rst = 1;
    repeat (2) @(posedge Clk);
    #1 Rst = 0; bus.Rsp_Ready_SI = 1;
    @(negedge Clk);
    n_chk++; if (bus.Rsp_Valid_SO !== 1'b0 || Outst !== 3'd0) begin
      n_fail++; $display("FAIL rst_flight: got v=%b o=%0d want 0/0", bus.Rsp_Valid_SO, Outst); end
    repeat (6) @(posedge Clk);
    #1;
    n_chk++; if (rq_data.size() !== 0) begin n_fail++; $display("FAIL rst_discard: got %0d want 0", rq_data.size()); end
    send(0, 8'h00, 10'h007, 64'h0, h, ok);
    bus.Req_Valid_SI = 0;
    wait_rsp(1, ok);
    n_chk++; if (!ok || rq_data[0] !== (BASE | 64'h7)) begin
      n_fail++; $display("FAIL rst_newread: got %h want %h", rq_data[0], BASE | 64'h7); end
  endtask

`ifdef SRAM_REQ_BYPASS_EN
  task automatic test_bypass();
    int h; bit ok;
    clear_q(); bus.Rsp_Ready_SI = 1;
    send(0, 8'h00, 10'h008, 64'h0, h, ok);
    bus.Req_Valid_SI = 0;
    wait_rsp(1, ok);
    n_chk++; if (!ok || rq_cyc[0] !== h + LAT || rq_data[0] !== (BASE | 64'h8)) begin
      n_fail++; $display("FAIL bypass: got lat=%0d d=%h want %0d/%h", rq_cyc[0] - h, rq_data[0], LAT, BASE | 64'h8); end
  endtask
`endif

  initial begin
    Rst = 1; bus.Req_Valid_SI = 0; bus.Req_We_SI = 0; bus.Req_BEn_SI = 0;
    bus.Req_Addr_DI = 0; bus.Req_WrData_DI = 0; bus.Rsp_Ready_SI = 0;
    @(posedge Clk); #1;
    test_reset();
    test_issue();
    test_write_read();
    test_partial_write();
    test_backpressure();
    test_back_to_back();
    test_reset_inflight();
`ifdef SRAM_REQ_BYPASS_EN
    test_bypass();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
